// File: rtl/decode_stage_sb.sv
// decode_stage_sb: registered decode stage with one register file per SP and a CAM scoreboard.
// Optional macro DECODE_WB_BYPASS_EN forwards same-cycle writeback data and lifts hazards on wb_done.
module decode_stage_sb #(
  parameter int I_DATA_WIDTH  = 32,
  parameter int R_DATA_WIDTH  = 32,
  parameter int R_ADDR_WIDTH  = 10,
  parameter int SP_PER_MP     = 8,
  parameter int CONTROL_WIDTH = 21,
  parameter int OP_WIDTH      = 6,
  parameter int FUNC_WIDTH    = 6,
  parameter int DEST_WIDTH    = 5,
  parameter int SRC_WIDTH     = 5,
  parameter int IMM_WIDTH     = 16,
  parameter int LDS_BIT       = 20,
  parameter int SB_DEPTH      = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    instr_valid_f,
  output logic                                    instr_ready_f,
  input  logic [I_DATA_WIDTH-1:0]                 instr_f,
  input  logic [R_ADDR_WIDTH-1:0]                 base_rval_f,
  input  logic [SP_PER_MP-1:0][R_DATA_WIDTH-1:0]  tids,
  input  logic [R_DATA_WIDTH-1:0]                 spec_d,
  input  logic                                    flush,
  input  logic [SP_PER_MP-1:0]                    rwe_wb,
  input  logic [R_ADDR_WIDTH-1:0]                 rwa_wb,
  input  logic [SP_PER_MP-1:0][R_DATA_WIDTH-1:0]  rdata_wb,
  input  logic                                    wb_done,
  output logic                                    valid_d,
  input  logic                                    ready_x,
  output logic [CONTROL_WIDTH-1:0]                control_d,
  output logic [SP_PER_MP-1:0][R_DATA_WIDTH-1:0]  src1_d,
  output logic [SP_PER_MP-1:0][R_DATA_WIDTH-1:0]  src2_d,
  output logic [SP_PER_MP-1:0][R_DATA_WIDTH-1:0]  src3_d,
  output logic [R_ADDR_WIDTH-1:0]                 rwa_d,
  output logic [IMM_WIDTH-1:0]                    imm_d,
  output logic [SRC_WIDTH-1:0]                    src1_o,
  output logic                                    sb_full
);

  localparam int SB_IDX_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam int RF_DEPTH = 1 << R_ADDR_WIDTH;
  localparam int DEST_MSB = I_DATA_WIDTH - OP_WIDTH - 1;
  localparam int SRC1_MSB = DEST_MSB - DEST_WIDTH;
  localparam int SRC2_MSB = SRC1_MSB - SRC_WIDTH;
  localparam int SRC3_MSB = SRC2_MSB - SRC_WIDTH;
  localparam logic [OP_WIDTH-1:0] LDS_OP = '1;

  logic [OP_WIDTH-1:0]     op_f;
  logic [DEST_WIDTH-1:0]   dest_f;
  logic [SRC_WIDTH-1:0]    src1_f, src2_f, src3_f;
  logic [FUNC_WIDTH-1:0]   func_f;
  logic [R_ADDR_WIDTH-1:0] dest_a, src1_a, src2_a, src3_a;
  logic                    is_lds, src1_chk;
  logic [CONTROL_WIDTH-1:0] ctrl_dec;

  assign op_f   = instr_f[I_DATA_WIDTH-1 -: OP_WIDTH];
  assign dest_f = instr_f[DEST_MSB -: DEST_WIDTH];
  assign src1_f = instr_f[SRC1_MSB -: SRC_WIDTH];
  assign src2_f = instr_f[SRC2_MSB -: SRC_WIDTH];
  assign src3_f = instr_f[SRC3_MSB -: SRC_WIDTH];
  assign func_f = instr_f[FUNC_WIDTH-1:0];

  // Absolute addresses wrap modulo the register-file depth.
  assign dest_a = base_rval_f + R_ADDR_WIDTH'(dest_f);
  assign src1_a = base_rval_f + R_ADDR_WIDTH'(src1_f);
  assign src2_a = base_rval_f + R_ADDR_WIDTH'(src2_f);
  assign src3_a = base_rval_f + R_ADDR_WIDTH'(src3_f);

  assign is_lds   = (op_f == LDS_OP);
  assign src1_chk = ~(is_lds & (&src1_f));

  always_comb begin
    ctrl_dec = '0;
    ctrl_dec[OP_WIDTH-1:0] = op_f;
    ctrl_dec[OP_WIDTH +: FUNC_WIDTH] = func_f;
    ctrl_dec[LDS_BIT] = is_lds;
  end

  logic [SB_DEPTH-1:0]     sb_valid_q, sb_valid_d;
  logic [R_ADDR_WIDTH-1:0] sb_addr_q [SB_DEPTH];
  logic [R_ADDR_WIDTH-1:0] sb_addr_d [SB_DEPTH];
  logic [SB_DEPTH-1:0]     sb_lift;
  logic [SB_IDX_W-1:0]     free_idx;
  logic [SB_IDX_W-1:0]     held_idx_q, held_idx_d;
  logic                    hazard, accept;
  logic                    valid_q, valid_d_n;

  always_comb begin
    sb_lift = '0;
`ifdef DECODE_WB_BYPASS_EN
    for (int i = 0; i < SB_DEPTH; i++) sb_lift[i] = wb_done && (sb_addr_q[i] == rwa_wb);
`endif
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb_valid_q[i] && !sb_lift[i] &&
          ((sb_addr_q[i] == dest_a) || (sb_addr_q[i] == src2_a) ||
           (sb_addr_q[i] == src3_a) || (src1_chk && (sb_addr_q[i] == src1_a))))
        hazard = 1'b1;
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = SB_DEPTH - 1; i >= 0; i--) if (!sb_valid_q[i]) free_idx = SB_IDX_W'(i);
  end

  // Handshake: a transfer happens on a side only in a cycle where both valid and ready are
  // high; the offering side keeps its payload stable until then, and ready never waits on valid.
  assign sb_full       = &sb_valid_q;
  assign instr_ready_f = ~rst & ~flush & (~valid_q | ready_x) & ~hazard & ~sb_full;
  assign accept        = instr_valid_f & instr_ready_f;

  // Retirement and flush act on the old entries; the new allocation is applied last.
  always_comb begin
    sb_valid_d = sb_valid_q;
    sb_addr_d  = sb_addr_q;
    held_idx_d = held_idx_q;
    if (wb_done) begin
      for (int i = 0; i < SB_DEPTH; i++)
        if (sb_valid_q[i] && (sb_addr_q[i] == rwa_wb)) sb_valid_d[i] = 1'b0;
    end
    if (flush && valid_q && !ready_x) sb_valid_d[held_idx_q] = 1'b0;
    if (accept) begin
      sb_valid_d[free_idx] = 1'b1;
      sb_addr_d[free_idx]  = dest_a;
      held_idx_d           = free_idx;
    end
  end

  always_comb begin
    if (flush)        valid_d_n = 1'b0;
    else if (accept)  valid_d_n = 1'b1;
    else if (ready_x) valid_d_n = 1'b0;
    else              valid_d_n = valid_q;
  end

  logic [R_DATA_WIDTH-1:0] rf_mem [SP_PER_MP][RF_DEPTH];

  always_ff @(posedge clk) begin
    for (int l = 0; l < SP_PER_MP; l++)
      if (rwe_wb[l]) rf_mem[l][rwa_wb] <= rdata_wb[l];
  end

  logic [SP_PER_MP-1:0][R_DATA_WIDTH-1:0] opnd1_q, opnd1_d, opnd2_q, opnd2_d, opnd3_q, opnd3_d;
  logic [R_DATA_WIDTH-1:0]  rd1, rd2, rd3;
  logic [CONTROL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [R_ADDR_WIDTH-1:0]  rwa_q, rwa_d_n;
  logic [IMM_WIDTH-1:0]     imm_q, imm_d_n;
  logic [SRC_WIDTH-1:0]     src1f_q, src1f_d;

  // Operands are captured only on accept, so a stalled output keeps its read data.
  always_comb begin
    opnd1_d = opnd1_q;
    opnd2_d = opnd2_q;
    opnd3_d = opnd3_q;
    ctrl_d  = ctrl_q;
    rwa_d_n = rwa_q;
    imm_d_n = imm_q;
    src1f_d = src1f_q;
    rd1 = '0;
    rd2 = '0;
    rd3 = '0;
    if (accept) begin
      ctrl_d  = ctrl_dec;
      rwa_d_n = dest_a;
      imm_d_n = instr_f[IMM_WIDTH-1:0];
      src1f_d = src1_f;
      for (int l = 0; l < SP_PER_MP; l++) begin
        rd1 = rf_mem[l][src1_a];
        rd2 = rf_mem[l][src2_a];
        rd3 = rf_mem[l][src3_a];
`ifdef DECODE_WB_BYPASS_EN
        if (rwe_wb[l] && (rwa_wb == src1_a)) rd1 = rdata_wb[l];
        if (rwe_wb[l] && (rwa_wb == src2_a)) rd2 = rdata_wb[l];
        if (rwe_wb[l] && (rwa_wb == src3_a)) rd3 = rdata_wb[l];
`endif
        if (!is_lds)          opnd1_d[l] = rd1;
        else if (&src1_f)     opnd1_d[l] = tids[l];
        else                  opnd1_d[l] = spec_d;
        opnd2_d[l] = rd2;
        opnd3_d[l] = rd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      sb_valid_q <= '0;
      held_idx_q <= '0;
      for (int i = 0; i < SB_DEPTH; i++) sb_addr_q[i] <= '0;
      opnd1_q    <= '0;
      opnd2_q    <= '0;
      opnd3_q    <= '0;
      ctrl_q     <= '0;
      rwa_q      <= '0;
      imm_q      <= '0;
      src1f_q    <= '0;
    end else begin
      valid_q    <= valid_d_n;
      sb_valid_q <= sb_valid_d;
      held_idx_q <= held_idx_d;
      for (int i = 0; i < SB_DEPTH; i++) sb_addr_q[i] <= sb_addr_d[i];
      opnd1_q    <= opnd1_d;
      opnd2_q    <= opnd2_d;
      opnd3_q    <= opnd3_d;
      ctrl_q     <= ctrl_d;
      rwa_q      <= rwa_d_n;
      imm_q      <= imm_d_n;
      src1f_q    <= src1f_d;
    end
  end

  assign valid_d   = valid_q;
  assign control_d = ctrl_q;
  assign src1_d    = opnd1_q;
  assign src2_d    = opnd2_q;
  assign src3_d    = opnd3_q;
  assign rwa_d     = rwa_q;
  assign imm_d     = imm_q;
  assign src1_o    = src1f_q;

endmodule

// File: tb/tb_decode_stage_sb.sv
// tb_decode_stage_sb: directed scenarios plus randomized traffic for decode_stage_sb,
// checked against a queue-based model of the pending destinations and register contents.
module tb_decode_stage_sb;

  localparam int IW = 32, RW = 32, AW = 10, SP = 8, CW = 21, SBD = 4;

  logic                   clk, rst, instr_valid_f, instr_ready_f, flush, wb_done;
  logic                   valid_d, ready_x, sb_full;
  logic [IW-1:0]          instr_f;
  logic [AW-1:0]          base_rval_f, rwa_wb, rwa_d;
  logic [SP-1:0][RW-1:0]  tids, rdata_wb, src1_d, src2_d, src3_d;
  logic [RW-1:0]          spec_d;
  logic [SP-1:0]          rwe_wb;
  logic [CW-1:0]          control_d;
  logic [15:0]            imm_d;
  logic [4:0]             src1_o;

  decode_stage_sb dut (
    .clk(clk), .rst(rst), .instr_valid_f(instr_valid_f), .instr_ready_f(instr_ready_f),
    .instr_f(instr_f), .base_rval_f(base_rval_f), .tids(tids), .spec_d(spec_d),
    .flush(flush), .rwe_wb(rwe_wb), .rwa_wb(rwa_wb), .rdata_wb(rdata_wb), .wb_done(wb_done),
    .valid_d(valid_d), .ready_x(ready_x), .control_d(control_d), .src1_d(src1_d),
    .src2_d(src2_d), .src3_d(src3_d), .rwa_d(rwa_d), .imm_d(imm_d), .src1_o(src1_o),
    .sb_full(sb_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish", $time);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  logic [RW-1:0]         rf_m [SP][1024];
  logic [AW-1:0]         pend_q[$];
  logic                  exp_valid;
  logic [CW-1:0]         exp_ctrl;
  logic [AW-1:0]         exp_rwa, exp_held;
  logic [15:0]           exp_imm;
  logic [4:0]            exp_s1o;
  logic [SP-1:0][RW-1:0] exp_s1, exp_s2, exp_s3;
  int                    n_tests, n_fail;

  function automatic logic [31:0] mk(int op, int d, int s1, int s2, int s3, int fn);
    return (32'(op) << 26) | (32'(d) << 21) | (32'(s1) << 16) | (32'(s2) << 11) |
           (32'(s3) << 6) | 32'(fn);
  endfunction

  function automatic logic [AW-1:0] abs_addr(int field);
    return AW'((int'(base_rval_f) + field) % 1024);
  endfunction

  function automatic bit m_busy(logic [AW-1:0] a);
    bit b = 1'b0;
    foreach (pend_q[i]) if (pend_q[i] == a) b = 1'b1;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_done && rwa_wb == a) b = 1'b0;
`endif
    return b;
  endfunction

  function automatic bit m_ready();
    int op, d, s1, s2, s3;
    bit hz;
    op = int'(instr_f >> 26);
    d  = int'((instr_f >> 21) & 31);
    s1 = int'((instr_f >> 16) & 31);
    s2 = int'((instr_f >> 11) & 31);
    s3 = int'((instr_f >> 6) & 31);
    hz = m_busy(abs_addr(d)) || m_busy(abs_addr(s2)) || m_busy(abs_addr(s3)) ||
         (!(op == 63 && s1 == 31) && m_busy(abs_addr(s1)));
    return !rst && !flush && (!exp_valid || ready_x) && !hz && (pend_q.size() < SBD);
  endfunction

  function automatic logic [RW-1:0] m_read(int lane, logic [AW-1:0] a);
    logic [RW-1:0] v;
    v = rf_m[lane][a];
`ifdef DECODE_WB_BYPASS_EN
    if (rwe_wb[lane] && rwa_wb == a) v = rdata_wb[lane];
`endif
    return v;
  endfunction

  // Advances the model by one clock using the inputs currently driven, then steps the DUT.
  task automatic tick();
    int  op, d, s1, s2, s3, fn;
    bit  acc, lds;
    acc = instr_valid_f && m_ready();
    op = int'(instr_f >> 26);
    d  = int'((instr_f >> 21) & 31);
    s1 = int'((instr_f >> 16) & 31);
    s2 = int'((instr_f >> 11) & 31);
    s3 = int'((instr_f >> 6) & 31);
    fn = int'(instr_f & 63);
    if (rst) begin
      exp_valid = 1'b0; exp_ctrl = '0; exp_rwa = '0; exp_imm = '0; exp_s1o = '0;
      exp_s1 = '0; exp_s2 = '0; exp_s3 = '0;
      pend_q.delete();
    end else begin
      if (wb_done)
        for (int i = pend_q.size() - 1; i >= 0; i--) if (pend_q[i] == rwa_wb) pend_q.delete(i);
      if (flush && exp_valid && !ready_x) begin
        for (int i = 0; i < pend_q.size(); i++)
          if (pend_q[i] == exp_held) begin pend_q.delete(i); break; end
      end
      if (acc) begin
        lds      = (op == 63);
        exp_ctrl = CW'(op + fn * 64 + (lds ? (1 << 20) : 0));
        exp_rwa  = abs_addr(d);
        exp_held = abs_addr(d);
        exp_imm  = 16'(instr_f % 65536);
        exp_s1o  = 5'(s1);
        for (int l = 0; l < SP; l++) begin
          exp_s1[l] = !lds ? m_read(l, abs_addr(s1)) : (s1 == 31 ? tids[l] : spec_d);
          exp_s2[l] = m_read(l, abs_addr(s2));
          exp_s3[l] = m_read(l, abs_addr(s3));
        end
        pend_q.push_back(abs_addr(d));
      end
      if (flush)        exp_valid = 1'b0;
      else if (acc)     exp_valid = 1'b1;
      else if (ready_x) exp_valid = 1'b0;
    end
    for (int l = 0; l < SP; l++) if (rwe_wb[l]) rf_m[l][rwa_wb] = rdata_wb[l];
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic rand_wdata();
    for (int l = 0; l < SP; l++) rdata_wb[l] = $urandom();
  endtask

  task automatic retire_all();
    instr_valid_f = 1'b0;
    rwe_wb = '0;
    for (int n = 0; n < 2 * SBD && pend_q.size() > 0; n++) begin
      wb_done = 1'b1;
      rwa_wb  = pend_q[0];
      tick();
    end
    wb_done = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    settle();
    n_tests += 4;
    if (valid_d !== 1'b0) begin n_fail++; $display("FAIL reset_valid_d: got %0b expected 0", valid_d); end
    if (sb_full !== 1'b0) begin n_fail++; $display("FAIL reset_sb_full: got %0b expected 0", sb_full); end
    if (instr_ready_f !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b expected 0", instr_ready_f); end
    if ({control_d, rwa_d, imm_d, src1_o} !== '0) begin
      n_fail++; $display("FAIL reset_regs: got ctrl=%0h rwa=%0h imm=%0h s1o=%0h expected all 0", control_d, rwa_d, imm_d, src1_o);
    end
    n_tests++;
    if ({src1_d, src2_d, src3_d} !== '0) begin n_fail++; $display("FAIL reset_src: got nonzero src data expected 0"); end
    rst = 1'b0;
  endtask

  task automatic init_regs();
    for (int a = 0; a < 1024; a++) begin
      rwe_wb = '1;
      rwa_wb = AW'(a);
      rand_wdata();
      tick();
    end
    rwe_wb = '0;
  endtask

  task automatic test_basic();
    ready_x = 1'b1;
    base_rval_f = 10'h010;
    instr_f = mk(1, 3, 1, 2, 4, 2);
    instr_valid_f = 1'b1;
    settle();
    n_tests++;
    if (instr_ready_f !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %0b expected 1", instr_ready_f); end
    tick();
    n_tests += 5;
    if (valid_d !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b expected 1", valid_d); end
    if (rwa_d !== 10'h013) begin n_fail++; $display("FAIL basic_rwa: got %0h expected 013", rwa_d); end
    if (src1_d !== exp_s1 || src2_d !== exp_s2 || src3_d !== exp_s3) begin
      n_fail++; $display("FAIL basic_src: got s1=%0h expected %0h", src1_d, exp_s1);
    end
    if (control_d !== exp_ctrl || imm_d !== exp_imm) begin
      n_fail++; $display("FAIL basic_ctrl: got ctrl=%0h imm=%0h expected ctrl=%0h imm=%0h", control_d, imm_d, exp_ctrl, exp_imm);
    end
    if (src1_o !== 5'd1) begin n_fail++; $display("FAIL basic_src1_o: got %0h expected 1", src1_o); end
  endtask

  task automatic test_back_to_back();
    logic [SP-1:0][RW-1:0] wb_data;
    bit exp_rdy;
    instr_f = mk(1, 7, 3, 5, 6, 0);
    instr_valid_f = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      n_tests++;
      if (instr_ready_f !== 1'b0) begin n_fail++; $display("FAIL b2b_blocked: cycle %0d got %0b expected 0", c, instr_ready_f); end
      tick();
    end
    rwe_wb = '1; rwa_wb = 10'h013; wb_done = 1'b1;
    rand_wdata();
    wb_data = rdata_wb;
`ifdef DECODE_WB_BYPASS_EN
    exp_rdy = 1'b1;
`else
    exp_rdy = 1'b0;
`endif
    settle();
    n_tests++;
    if (instr_ready_f !== exp_rdy) begin n_fail++; $display("FAIL b2b_wb_cycle_ready: got %0b expected %0b", instr_ready_f, exp_rdy); end
    tick();
    rwe_wb = '0; wb_done = 1'b0;
`ifndef DECODE_WB_BYPASS_EN
    settle();
    n_tests++;
    if (instr_ready_f !== 1'b1) begin n_fail++; $display("FAIL b2b_after_wb_ready: got %0b expected 1", instr_ready_f); end
    tick();
`endif
    n_tests += 3;
    if (valid_d !== 1'b1 || rwa_d !== 10'h017) begin n_fail++; $display("FAIL b2b_issue: got valid=%0b rwa=%0h expected 1/017", valid_d, rwa_d); end
    if (src1_d !== wb_data) begin n_fail++; $display("FAIL b2b_src1_data: got %0h expected %0h", src1_d, wb_data); end
    if (src2_d !== exp_s2 || src3_d !== exp_s3) begin n_fail++; $display("FAIL b2b_src23: got %0h expected %0h", src2_d, exp_s2); end
    instr_valid_f = 1'b0;
    tick();
  endtask

  task automatic test_lds();
    logic [SP-1:0][RW-1:0] want;
    retire_all();
    ready_x = 1'b1;
    base_rval_f = '0;
    for (int l = 0; l < SP; l++) begin tids[l] = RW'(l); want[l] = RW'(l); end
    instr_f = mk(63, 9, 31, 1, 2, 0);
    instr_valid_f = 1'b1;
    tick();
    n_tests += 2;
    if (src1_d !== want) begin n_fail++; $display("FAIL lds_tid: got %0h expected %0h", src1_d, want); end
    if (control_d[20] !== 1'b1) begin n_fail++; $display("FAIL lds_ctrl_bit: got %0b expected 1", control_d[20]); end
    spec_d = 32'hDEAD;
    for (int l = 0; l < SP; l++) begin tids[l] = $urandom(); want[l] = 32'hDEAD; end
    instr_f = mk(63, 10, 2, 3, 4, 0);
    tick();
    n_tests += 2;
    if (src1_d !== want) begin n_fail++; $display("FAIL lds_spec: got %0h expected %0h", src1_d, want); end
    if (src2_d !== exp_s2) begin n_fail++; $display("FAIL lds_src2: got %0h expected %0h", src2_d, exp_s2); end
    instr_valid_f = 1'b0;
    tick();
  endtask

  task automatic test_sb_full();
    retire_all();
    ready_x = 1'b1;
    base_rval_f = 10'h100;
    instr_valid_f = 1'b1;
    for (int k = 0; k < SBD; k++) begin
      instr_f = mk(2, 8 + k, 20, 21, 22, k);
      tick();
    end
    instr_f = mk(2, 12, 20, 21, 22, 5);
    settle();
    n_tests += 2;
    if (sb_full !== 1'b1) begin n_fail++; $display("FAIL sbf_full: got %0b expected 1", sb_full); end
    if (instr_ready_f !== 1'b0) begin n_fail++; $display("FAIL sbf_blocked: got %0b expected 0", instr_ready_f); end
    wb_done = 1'b1; rwa_wb = 10'h108;
    settle();
    n_tests++;
    if (sb_full !== 1'b1) begin n_fail++; $display("FAIL sbf_same_cycle: got %0b expected 1", sb_full); end
    tick();
    wb_done = 1'b0;
    settle();
    n_tests += 2;
    if (sb_full !== 1'b0) begin n_fail++; $display("FAIL sbf_freed: got %0b expected 0", sb_full); end
    if (instr_ready_f !== 1'b1) begin n_fail++; $display("FAIL sbf_fifth_ready: got %0b expected 1", instr_ready_f); end
    tick();
    n_tests++;
    if (valid_d !== 1'b1 || rwa_d !== 10'h10C) begin n_fail++; $display("FAIL sbf_fifth_issue: got valid=%0b rwa=%0h expected 1/10c", valid_d, rwa_d); end
    instr_valid_f = 1'b0;
    tick();
  endtask

  task automatic test_stall_flush();
    retire_all();
    tick();
    ready_x = 1'b0;
    base_rval_f = 10'h200;
    instr_f = mk(3, 1, 2, 3, 4, 7);
    instr_valid_f = 1'b1;
    settle();
    n_tests++;
    if (instr_ready_f !== 1'b1) begin n_fail++; $display("FAIL stall_first_ready: got %0b expected 1", instr_ready_f); end
    tick();
    instr_f = mk(3, 9, 10, 11, 12, 0);
    for (int c = 0; c < 3; c++) begin
      rwe_wb = '1; rwa_wb = 10'h202;
      rand_wdata();
      settle();
      n_tests++;
      if (instr_ready_f !== 1'b0) begin n_fail++; $display("FAIL stall_ready: cycle %0d got %0b expected 0", c, instr_ready_f); end
      tick();
      n_tests++;
      if (valid_d !== 1'b1 || rwa_d !== 10'h201 || src1_d !== exp_s1 || src2_d !== exp_s2) begin
        n_fail++; $display("FAIL stall_hold: cycle %0d got valid=%0b rwa=%0h s1=%0h expected 1/201/%0h", c, valid_d, rwa_d, src1_d, exp_s1);
      end
    end
    rwe_wb = '0;
    flush = 1'b1;
    instr_valid_f = 1'b0;
    tick();
    flush = 1'b0;
    n_tests++;
    if (valid_d !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0b expected 0", valid_d); end
    instr_f = mk(3, 5, 1, 6, 7, 0);
    instr_valid_f = 1'b1;
    ready_x = 1'b1;
    settle();
    n_tests++;
    if (instr_ready_f !== 1'b1) begin n_fail++; $display("FAIL flush_entry_freed: got %0b expected 1", instr_ready_f); end
    tick();
    n_tests++;
    if (valid_d !== 1'b1 || src1_d !== exp_s1) begin n_fail++; $display("FAIL flush_next_issue: got valid=%0b s1=%0h expected 1/%0h", valid_d, src1_d, exp_s1); end
    instr_valid_f = 1'b0;
    tick();
  endtask

  task automatic test_wrap_reset();
    retire_all();
    ready_x = 1'b1;
    base_rval_f = 10'h3FE;
    instr_f = mk(4, 5, 3, 1, 31, 0);
    instr_valid_f = 1'b1;
    tick();
    n_tests += 2;
    if (rwa_d !== 10'h003) begin n_fail++; $display("FAIL wrap_rwa: got %0h expected 003", rwa_d); end
    if (src1_d !== exp_s1 || src3_d !== exp_s3) begin n_fail++; $display("FAIL wrap_src: got %0h expected %0h", src1_d, exp_s1); end
    base_rval_f = 10'h040;
    for (int k = 1; k < SBD; k++) begin
      instr_f = mk(4, k, 20, 21, 22, 0);
      tick();
    end
    instr_f = mk(4, 9, 20, 21, 22, 0);
    ready_x = 1'b0;
    tick();
    settle();
    n_tests++;
    if (sb_full !== 1'b1) begin n_fail++; $display("FAIL wrap_full_before_rst: got %0b expected 1", sb_full); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    instr_valid_f = 1'b0;
    settle();
    n_tests += 2;
    if (valid_d !== 1'b0 || rwa_d !== '0) begin n_fail++; $display("FAIL midrst_valid: got valid=%0b rwa=%0h expected 0/0", valid_d, rwa_d); end
    if (sb_full !== 1'b0) begin n_fail++; $display("FAIL midrst_sb_full: got %0b expected 0", sb_full); end
  endtask

  task automatic test_random();
    int op, s1;
    for (int c = 0; c < 400; c++) begin
      op = ($urandom_range(0, 3) == 0) ? 63 : int'($urandom_range(0, 62));
      s1 = (op == 63 && $urandom_range(0, 1) == 1) ? 31 : int'($urandom_range(0, 7));
      base_rval_f = ($urandom_range(0, 1) == 1) ? 10'h3FC : 10'h000;
      instr_f = mk(op, int'($urandom_range(0, 7)), s1, int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 63)));
      instr_valid_f = ($urandom_range(0, 3) != 0);
      ready_x = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 19) == 0);
      spec_d = $urandom();
      for (int l = 0; l < SP; l++) tids[l] = $urandom();
      rwe_wb = SP'($urandom());
      rand_wdata();
      if (pend_q.size() > 0 && $urandom_range(0, 9) < 4) begin
        wb_done = 1'b1;
        rwa_wb = pend_q[$urandom_range(0, pend_q.size() - 1)];
      end else begin
        wb_done = 1'b0;
        rwa_wb = AW'($urandom_range(0, 1023));
      end
      settle();
      n_tests++;
      if (instr_ready_f !== m_ready()) begin n_fail++; $display("FAIL rand_ready: cycle %0d got %0b expected %0b", c, instr_ready_f, m_ready()); end
      tick();
      n_tests += 2;
      if (valid_d !== exp_valid || sb_full !== (pend_q.size() == SBD)) begin
        n_fail++; $display("FAIL rand_state: cycle %0d got valid=%0b full=%0b expected %0b/%0b", c, valid_d, sb_full, exp_valid, pend_q.size() == SBD);
      end
      if (exp_valid && ({rwa_d, control_d, imm_d, src1_o, src1_d, src2_d, src3_d} !==
                        {exp_rwa, exp_ctrl, exp_imm, exp_s1o, exp_s1, exp_s2, exp_s3})) begin
        n_fail++; $display("FAIL rand_outputs: cycle %0d got rwa=%0h ctrl=%0h s1=%0h expected rwa=%0h ctrl=%0h s1=%0h", c, rwa_d, control_d, src1_d, exp_rwa, exp_ctrl, exp_s1);
      end
    end
    flush = 1'b0; wb_done = 1'b0; rwe_wb = '0; instr_valid_f = 1'b0;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; instr_valid_f = 1'b0; instr_f = '0; base_rval_f = '0; tids = '0; spec_d = '0;
    flush = 1'b0; rwe_wb = '0; rwa_wb = '0; rdata_wb = '0; wb_done = 1'b0; ready_x = 1'b0;
    exp_valid = 1'b0; exp_held = '0;
    @(posedge clk);
    #1;
    test_reset();
    init_regs();
    test_basic();
    test_back_to_back();
    test_lds();
    test_sb_full();
    test_stall_flush();
    test_wrap_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
